// File: rtl/fix_inject.sv
// fix_inject: valid/ready stream sequencer that emits the constant VAL, flagged on
// dout_ins, after every PERIOD accepted input tokens (PERIOD=0 gives a plain register stage).
module fix_inject #(
   parameter int DIN    = 8,
   parameter int VAL    = 0,
   parameter int PERIOD = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           din_valid,
   output logic           din_ready,
   input  logic [DIN-1:0] din_data,
   output logic           dout_valid,
   input  logic           dout_ready,
   output logic [DIN-1:0] dout_data,
   output logic           dout_ins
);
   localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam logic [DIN-1:0] VAL_T = DIN'(VAL);

   typedef enum logic {PASS, INJ} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             valid_q, valid_d;
   logic [DIN-1:0]   data_q, data_d;
   logic             ins_q, ins_d;
   logic             free, acc, wrap;

   always_comb begin
      free      = !valid_q || dout_ready;
      din_ready = rst && state_q == PASS && free;
      acc       = din_valid && din_ready;
      wrap      = PERIOD > 0 && cnt_q == CNT_W'(PERIOD - 1);
      state_d   = state_q;
      cnt_d     = cnt_q;
      valid_d   = valid_q;
      data_d    = data_q;
      ins_d     = ins_q;
      if (state_q == INJ) begin
         if (free) begin
            valid_d = 1'b1;
            data_d  = VAL_T;
            ins_d   = 1'b1;
            state_d = PASS;
         end
      end else if (acc) begin
         valid_d = 1'b1;
         data_d  = din_data;
         ins_d   = 1'b0;
         cnt_d   = (wrap || PERIOD == 0) ? '0 : cnt_q + 1'b1;
         state_d = wrap ? INJ : PASS;
      end else if (free) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= PASS;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         data_q  <= '0;
         ins_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         ins_q   <= ins_d;
      end
   end

   assign dout_valid = valid_q;
   assign dout_data  = data_q;
   assign dout_ins   = ins_q;
endmodule

// File: tb/tb_fix_inject.sv
// tb_fix_inject: four fix_inject configurations checked every cycle against a
// token-queue model of the expected output stream.
module tb_fix_inject;
   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] dv, dr, ov, ordy, oi;
   logic [7:0] dd [4];
   logic [7:0] od [4];
   logic [3:0] od3;

   always #5 clk = ~clk;
   assign od[3] = {4'h0, od3};

   fix_inject #(.DIN(8), .VAL('hAA), .PERIOD(3)) u0 (.clk(clk), .rst(rst), .din_valid(dv[0]), .din_ready(dr[0]),
      .din_data(dd[0]), .dout_valid(ov[0]), .dout_ready(ordy[0]), .dout_data(od[0]), .dout_ins(oi[0]));
   fix_inject #(.DIN(8), .VAL('h5A), .PERIOD(1)) u1 (.clk(clk), .rst(rst), .din_valid(dv[1]), .din_ready(dr[1]),
      .din_data(dd[1]), .dout_valid(ov[1]), .dout_ready(ordy[1]), .dout_data(od[1]), .dout_ins(oi[1]));
   fix_inject #(.DIN(8), .VAL('h33), .PERIOD(0)) u2 (.clk(clk), .rst(rst), .din_valid(dv[2]), .din_ready(dr[2]),
      .din_data(dd[2]), .dout_valid(ov[2]), .dout_ready(ordy[2]), .dout_data(od[2]), .dout_ins(oi[2]));
   fix_inject #(.DIN(4), .VAL('h1F), .PERIOD(3)) u3 (.clk(clk), .rst(rst), .din_valid(dv[3]), .din_ready(dr[3]),
      .din_data(dd[3][3:0]), .dout_valid(ov[3]), .dout_ready(ordy[3]), .dout_data(od3), .dout_ins(oi[3]));

   int         per  [4] = '{3, 1, 0, 3};
   logic [7:0] vals [4] = '{8'hAA, 8'h5A, 8'h33, 8'h0F};
   logic [7:0] msk  [4] = '{8'hFF, 8'hFF, 8'hFF, 8'h0F};
   int         rmode[4];
   int         cnt_m[4];
   logic [8:0] q    [4][$];
   logic [8:0] outq [4][$];
   logic [7:0] src  [4][$];
   logic       gaps;
   int         cyc, tests, fails;

   logic [8:0] exp0[$] = '{9'h000, 9'h001, 9'h002, 9'h1AA, 9'h003, 9'h004, 9'h005, 9'h1AA, 9'h006, 9'h007};
   logic [8:0] exp1[$] = '{9'h010, 9'h15A, 9'h011, 9'h15A, 9'h012, 9'h15A};
   logic [8:0] exp3[$] = '{9'h000, 9'h001, 9'h002, 9'h10F, 9'h003, 9'h004, 9'h005, 9'h10F, 9'h006, 9'h007};
   logic [8:0] expc[$] = '{9'h007, 9'h008, 9'h009, 9'h1AA, 9'h00A};

   task automatic chk(input string tag, input int i, input logic [8:0] got, input logic [8:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s[%0d]: got %h expected %h", tag, i, got, exp);
      end
   endtask

   function automatic bit busy();
      for (int i = 0; i < 4; i++) if (src[i].size() > 0 || q[i].size() > 0) return 1'b1;
      return 1'b0;
   endfunction

   // Each queued entry is {ins, data}; the head is what the output register must show.
   task automatic one_cycle();
      int sz;
      for (int i = 0; i < 4; i++) begin
         dv[i]   = src[i].size() > 0 && (!gaps || $urandom_range(0, 3) != 0);
         dd[i]   = src[i].size() > 0 ? src[i][0] : 8'($urandom);
         ordy[i] = rmode[i] == 0 ? 1'b1 : rmode[i] == 1 ? cyc[0] : rmode[i] == 2 ? 1'($urandom) : 1'b0;
      end
      #1;
      for (int i = 0; i < 4; i++) begin
         sz = q[i].size();
         chk("dout_valid", i, 9'(ov[i]), 9'(sz > 0));
         if (sz > 0) chk("dout_token", i, {oi[i], od[i]}, q[i][0]);
         chk("din_ready", i, 9'(dr[i]), 9'(rst && sz < 2 && (sz == 0 || ordy[i])));
         if (ov[i] && ordy[i]) begin
            outq[i].push_back({oi[i], od[i]});
            if (sz > 0) void'(q[i].pop_front());
         end
         if (dv[i] && dr[i]) begin
            q[i].push_back({1'b0, dd[i] & msk[i]});
            void'(src[i].pop_front());
            cnt_m[i]++;
            if (per[i] > 0 && cnt_m[i] == per[i]) begin
               cnt_m[i] = 0;
               q[i].push_back({1'b1, vals[i]});
            end
         end
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic clear_model();
      for (int i = 0; i < 4; i++) begin
         q[i].delete();
         outq[i].delete();
         src[i].delete();
         cnt_m[i] = 0;
      end
   endtask

   task automatic do_reset();
      rst = 1'b0;
      clear_model();
      one_cycle();
      one_cycle();
      for (int i = 0; i < 4; i++) begin
         chk("rst_data", i, 9'(od[i]), 9'h000);
         chk("rst_ins", i, 9'(oi[i]), 9'h000);
      end
      rst = 1'b1;
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while (busy() && n < budget) begin
         one_cycle();
         n++;
      end
      chk("drain_done", 0, 9'(busy()), 9'h000);
   endtask

   task automatic chk_log(input int i, input logic [8:0] e[$]);
      chk("out_count", i, 9'(outq[i].size()), 9'(e.size()));
      for (int k = 0; k < e.size() && k < outq[i].size(); k++) chk("out_seq", i, outq[i][k], e[k]);
   endtask

   initial begin
      rst   = 1'b0;
      gaps  = 1'b0;
      dv    = '0;
      ordy  = '0;
      rmode = '{0, 0, 0, 0};
      for (int i = 0; i < 4; i++) dd[i] = '0;
      @(negedge clk);
      do_reset();
      for (int v = 0; v < 8; v++) begin
         src[0].push_back(8'(v));
         src[3].push_back(8'(v));
      end
      for (int v = 0; v < 3; v++) src[1].push_back(8'(8'h10 + v));
      for (int v = 0; v < 16; v++) src[2].push_back(8'(v));
      drain(200);
      chk_log(0, exp0);
      chk_log(1, exp1);
      chk_log(3, exp3);
      do_reset();
      gaps  = 1'b1;
      rmode = '{1, 2, 2, 2};
      for (int v = 0; v < 8; v++) src[0].push_back(8'(v));
      for (int i = 1; i < 4; i++)
         for (int k = 0; k < 20; k++) src[i].push_back(8'($urandom));
      drain(800);
      chk_log(0, exp0);
      gaps = 1'b0;
      do_reset();
      rmode = '{0, 0, 0, 0};
      for (int v = 0; v < 3; v++) src[0].push_back(8'(v));
      repeat (3) one_cycle();
      rmode = '{3, 3, 3, 3};
      repeat (2) one_cycle();
      #2 rst = 1'b0;
      #1;
      chk("async_valid", 0, 9'(ov[0]), 9'h000);
      chk("async_data", 0, 9'(od[0]), 9'h000);
      chk("async_ready", 0, 9'(dr[0]), 9'h000);
      clear_model();
      @(negedge clk);
      rst   = 1'b1;
      rmode = '{0, 0, 0, 0};
      for (int v = 7; v < 11; v++) src[0].push_back(8'(v));
      drain(100);
      chk_log(0, expc);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
